// File: rtl/fft_frame_ctrl_if.sv
// Input sample stream and output bin stream of the FFT frame sequencer.
// slave = the sequencer side, master = the source/sink side.
interface fft_frame_ctrl_if #(
    parameter int IWIDTH = 12,
    parameter int OWIDTH = 19,
    parameter int LGN    = 12
);
    logic                  s_valid;
    logic                  s_ready;
    logic [2*IWIDTH-1:0]   s_left;
    logic [2*IWIDTH-1:0]   s_right;
    logic                  m_valid;
    logic                  m_ready;
    logic [2*OWIDTH-1:0]   m_left;
    logic [2*OWIDTH-1:0]   m_right;
    logic [LGN-1:0]        m_bin;
    logic                  m_last;

    modport slave (
        input  s_valid, s_left, s_right, m_ready,
        output s_ready, m_valid, m_left, m_right, m_bin, m_last
    );

    modport master (
        output s_valid, s_left, s_right, m_ready,
        input  s_ready, m_valid, m_left, m_right, m_bin, m_last
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a 2-sample/clock FFT core: owns core reset and clock enable.
// Optional FFT_FRAME_CTRL_LATCNT_EN adds o_latency (ce-cycles from LOAD entry to first output beat).
module fft_frame_ctrl #(
    parameter int IWIDTH  = 12,
    parameter int OWIDTH  = 19,
    parameter int LGN     = 12,
    parameter int MAX_LAT = 16384
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic                i_abort,
    fft_frame_ctrl_if.slave     strm,
    output logic                o_fft_reset,
    output logic                o_fft_ce,
    output logic [2*IWIDTH-1:0] o_fft_left,
    output logic [2*IWIDTH-1:0] o_fft_right,
    input  logic [2*OWIDTH-1:0] i_fft_left,
    input  logic [2*OWIDTH-1:0] i_fft_right,
    input  logic                i_fft_sync,
    output logic                o_busy,
    output logic                o_done,
`ifdef FFT_FRAME_CTRL_LATCNT_EN
    output logic [15:0]         o_latency,
`endif
    output logic                o_timeout
);
    localparam int             LW       = $clog2(MAX_LAT + 1);
    localparam logic [LGN-2:0] CNT_LAST = '1;
    localparam logic [LW-1:0]  LAT_LAST = LW'(MAX_LAT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t         state;
    logic [LGN-2:0] in_cnt;
    logic [LGN-2:0] out_cnt;
    logic [LW-1:0]  lat_cnt;
    logic           out_phase;
    logic           out_active;
    logic           adv;
    logic           flow;
    logic           in_xfer;
    logic           out_xfer;
    logic           in_load;

    // The core only advances when the sink can take whatever it presents.
    assign in_load    = (state == LOAD);
    assign out_active = out_phase || i_fft_sync;
    assign adv        = (in_load && strm.s_valid) || (state == FLUSH);
    assign flow       = !out_active || strm.m_ready;
    assign o_fft_ce   = adv && flow;
    assign strm.s_ready = in_load && flow;
    assign strm.m_valid = out_active && adv;
    assign in_xfer    = strm.s_valid && strm.s_ready;
    assign out_xfer   = strm.m_valid && strm.m_ready;

    assign o_fft_reset = (state == IDLE);
    assign o_fft_left  = in_load ? strm.s_left  : '0;
    assign o_fft_right = in_load ? strm.s_right : '0;

    assign strm.m_left  = i_fft_left;
    assign strm.m_right = i_fft_right;
    assign strm.m_bin   = {out_cnt, 1'b0};
    assign strm.m_last  = (out_cnt == CNT_LAST);
    assign o_busy       = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            lat_cnt   <= '0;
            out_phase <= 1'b0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
`ifdef FFT_FRAME_CTRL_LATCNT_EN
            o_latency <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            if (state == IDLE) begin
                if (i_start && !i_abort) begin
                    state     <= LOAD;
                    in_cnt    <= '0;
                    out_cnt   <= '0;
                    lat_cnt   <= '0;
                    out_phase <= 1'b0;
                    o_timeout <= 1'b0;
`ifdef FFT_FRAME_CTRL_LATCNT_EN
                    o_latency <= '0;
`endif
                end
            end else if (i_abort) begin
                state <= IDLE;
            end else begin
                if (in_xfer) begin
                    in_cnt <= in_cnt + 1'b1;
                    if (in_cnt == CNT_LAST)
                        state <= FLUSH;
                end
                // Late syncs are ignored once the output phase has begun.
                if (out_xfer) begin
                    out_cnt   <= out_cnt + 1'b1;
                    out_phase <= 1'b1;
`ifdef FFT_FRAME_CTRL_LATCNT_EN
                    if (!out_phase)
                        o_latency <= 16'(lat_cnt);
`endif
                    if (strm.m_last) begin
                        state  <= IDLE;
                        o_done <= 1'b1;
                    end
                end
                if (o_fft_ce && !out_active) begin
                    if (lat_cnt == LAT_LAST) begin
                        o_timeout <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl against a fixed-latency stub core (output = delayed input).
module tb_fft_frame_ctrl;
    localparam int IW   = 12;
    localparam int OW   = 19;
    localparam int LG   = 12;
    localparam int NB   = 2048;
    localparam int LAT  = 3000;
    localparam int MAXL = 5000;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    logic i_start = 1'b0;
    logic i_abort = 1'b0;
    always #5 i_clk = ~i_clk;

    fft_frame_ctrl_if #(.IWIDTH(IW), .OWIDTH(OW), .LGN(LG)) strm ();

    logic            o_fft_reset, o_fft_ce, i_fft_sync, o_busy, o_done, o_timeout;
    logic [2*IW-1:0] o_fft_left, o_fft_right;
    logic [2*OW-1:0] i_fft_left, i_fft_right;
`ifdef FFT_FRAME_CTRL_LATCNT_EN
    logic [15:0]     o_latency;
`endif

    fft_frame_ctrl #(.IWIDTH(IW), .OWIDTH(OW), .LGN(LG), .MAX_LAT(MAXL)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_abort(i_abort),
        .strm(strm.slave),
        .o_fft_reset(o_fft_reset), .o_fft_ce(o_fft_ce),
        .o_fft_left(o_fft_left), .o_fft_right(o_fft_right),
        .i_fft_left(i_fft_left), .i_fft_right(i_fft_right), .i_fft_sync(i_fft_sync),
        .o_busy(o_busy), .o_done(o_done),
`ifdef FFT_FRAME_CTRL_LATCNT_EN
        .o_latency(o_latency),
`endif
        .o_timeout(o_timeout)
    );

    function automatic logic [2*IW-1:0] dat_l(input int k);
        return {12'(k), 12'(k ^ 32'hA5A)};
    endfunction
    function automatic logic [2*IW-1:0] dat_r(input int k);
        return {12'(3 * k), 12'(k + 7)};
    endfunction

    // Stub core: sync and beat 0 appear stub_lat clock-enabled cycles after reset release.
    int              stub_lat = LAT;
    int              ce_idx = 0;
    logic [2*IW-1:0] mem_l [0:8191];
    logic [2*IW-1:0] mem_r [0:8191];

    always @(posedge i_clk) begin
        if (o_fft_reset) ce_idx <= 0;
        else if (o_fft_ce) begin
            if (ce_idx < 8192) begin
                mem_l[ce_idx] <= o_fft_left;
                mem_r[ce_idx] <= o_fft_right;
            end
            ce_idx <= ce_idx + 1;
        end
    end

    always_comb begin
        i_fft_sync  = 1'b0;
        i_fft_left  = '0;
        i_fft_right = '0;
        if (!o_fft_reset && ce_idx >= stub_lat && ce_idx - stub_lat < 8192) begin
            i_fft_sync  = (ce_idx == stub_lat);
            i_fft_left  = (2*OW)'(mem_l[ce_idx - stub_lat]);
            i_fft_right = (2*OW)'(mem_r[ce_idx - stub_lat]);
        end
    end

    // Output monitor: running totals; the directed sequence compares deltas.
    int   oidx = 0, beats = 0, bad = 0, last_cnt = 0, done_cnt = 0, done_bad = 0, ce_total = 0;
    logic last_prev = 1'b0;

    always @(negedge i_clk) begin
        if (o_fft_ce) ce_total <= ce_total + 1;
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            if (!last_prev) done_bad <= done_bad + 1;
        end
        last_prev <= strm.m_valid && strm.m_ready && strm.m_last;
        if (strm.m_valid && strm.m_ready) begin
            beats <= beats + 1;
            if (strm.m_bin !== 12'(2 * oidx) || strm.m_left !== (2*OW)'(dat_l(oidx)) ||
                strm.m_right !== (2*OW)'(dat_r(oidx)) || strm.m_last !== (oidx == NB - 1))
                bad <= bad + 1;
            if (strm.m_last) last_cnt <= last_cnt + 1;
        end
        if (o_fft_reset) oidx <= 0;
        else if (strm.m_valid && strm.m_ready) oidx <= oidx + 1;
    end

    int checks = 0, errors = 0;
    int b0, bd0, l0, d0, db0, c0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic snap();
        b0 = beats; bd0 = bad; l0 = last_cnt; d0 = done_cnt; db0 = done_bad; c0 = ce_total;
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Feeds nbeats input beats (data index base..), s_valid high one cycle in gap.
    task automatic feed(input string tag, input int gap, input int base, input int nbeats,
                        output int ce_in);
        int   k = 0;
        int   cyc = 0;
        logic acc;
        ce_in = 0;
        while (k < nbeats && cyc < 20000) begin
            strm.s_valid = (cyc % gap) == 0;
            strm.s_left  = dat_l(base + k);
            strm.s_right = dat_r(base + k);
            #1;
            if (o_fft_ce) ce_in++;
            acc = strm.s_valid && strm.s_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        strm.s_valid = 1'b0;
        chk({tag, "_fed"}, k, nbeats);
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        while (!o_done && n < 20000) begin tick(); n++; end
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_rst_after"}, o_fft_reset, 1);
        chk({tag, "_busy_after"}, o_busy, 0);
        tick();
        chk({tag, "_done_width"}, o_done, 0);
        chk({tag, "_beats"}, beats - b0, NB);
        chk({tag, "_order"}, bad - bd0, 0);
        chk({tag, "_last_cnt"}, last_cnt - l0, 1);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_done_after_last"}, done_bad - db0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ce_in, n, stall_ce, stall_rdy, stall_chg, stall_vld;
        logic [2*OW-1:0] held;
        strm.s_valid = 1'b0; strm.s_left = '0; strm.s_right = '0; strm.m_ready = 1'b1;
        repeat (3) tick();
        i_reset_n = 1'b1;
        tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_fft_reset", o_fft_reset, 1);
        chk("rst_ce", o_fft_ce, 0);
        chk("rst_s_ready", strm.s_ready, 0);
        chk("rst_m_valid", strm.m_valid, 0);
        chk("rst_done", o_done, 0);
        chk("rst_timeout", o_timeout, 0);

        // Frame A: continuous input, sink always ready.
        snap();
        start_frame();
        chk("a_load_rst", o_fft_reset, 0);
        chk("a_busy", o_busy, 1);
        feed("a", 1, 0, NB, ce_in);
        chk("a_load_ce", ce_in, NB);
        strm.s_valid = 1'b1; strm.s_left = '1; strm.s_right = '1;
        #1;
        chk("a_flush_zero_l", o_fft_left, 0);
        chk("a_flush_zero_r", o_fft_right, 0);
        chk("a_flush_s_ready", strm.s_ready, 0);
        strm.s_valid = 1'b0;
        finish_frame("a");
`ifdef FFT_FRAME_CTRL_LATCNT_EN
        chk("a_latency", o_latency, LAT);
`endif

        // Frame B: input valid one cycle in three.
        snap();
        start_frame();
        feed("b", 3, 0, NB, ce_in);
        chk("b_load_ce", ce_in, NB);
        finish_frame("b");
`ifdef FFT_FRAME_CTRL_LATCNT_EN
        chk("b_latency", o_latency, LAT);
`endif

        // Frame C: 50-cycle sink stall while bin 1000 is presented.
        snap();
        start_frame();
        feed("c", 1, 0, NB, ce_in);
        n = 0;
        while (!(strm.m_valid && strm.m_bin == 12'd1000) && n < 10000) begin tick(); n++; end
        chk("c_reach_bin1000", strm.m_bin, 1000);
        strm.m_ready = 1'b0;
        held = strm.m_left;
        stall_ce = 0; stall_rdy = 0; stall_chg = 0; stall_vld = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (o_fft_ce) stall_ce++;
            if (strm.s_ready) stall_rdy++;
            if (strm.m_left !== held) stall_chg++;
            if (!strm.m_valid) stall_vld++;
            tick();
        end
        chk("c_stall_ce", stall_ce, 0);
        chk("c_stall_s_ready", stall_rdy, 0);
        chk("c_stall_m_left", stall_chg, 0);
        chk("c_stall_m_valid", stall_vld, 0);
        chk("c_stall_bin", strm.m_bin, 1000);
        strm.m_ready = 1'b1;
        finish_frame("c");

        // Timeout: stub never syncs.
        stub_lat = 100000;
        snap();
        start_frame();
        feed("t", 1, 0, NB, ce_in);
        n = 0;
        while (!o_timeout && n < 10000) begin tick(); n++; end
        chk("t_timeout", o_timeout, 1);
        chk("t_ce_cycles", ce_total - c0, MAXL);
        chk("t_busy", o_busy, 0);
        chk("t_fft_reset", o_fft_reset, 1);
        chk("t_no_beats", beats - b0, 0);
        stub_lat = LAT;
        start_frame();
        chk("t_cleared_by_start", o_timeout, 0);
        chk("t_busy_again", o_busy, 1);

        // Abort together with start at in_cnt=700.
        feed("ab", 1, 0, 700, ce_in);
        i_abort = 1'b1; i_start = 1'b1; strm.s_valid = 1'b1;
        tick();
        i_abort = 1'b0; i_start = 1'b0; strm.s_valid = 1'b0;
        chk("ab_busy", o_busy, 0);
        chk("ab_fft_reset", o_fft_reset, 1);
        i_abort = 1'b1; i_start = 1'b1;
        tick();
        i_abort = 1'b0; i_start = 1'b0;
        chk("ab_idle_abort_wins", o_busy, 0);

        // Fresh frame with a stray start mid-LOAD that must be ignored.
        snap();
        start_frame();
        feed("f1", 1, 0, 1000, ce_in);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("f_busy_start_ignored", o_busy, 1);
        feed("f2", 1, 1000, NB - 1000, ce_in);
        finish_frame("f");

        // Reset during FLUSH while output is streaming.
        start_frame();
        feed("r", 1, 0, NB, ce_in);
        n = 0;
        while (!(strm.m_valid && strm.m_bin >= 12'd400) && n < 10000) begin tick(); n++; end
        chk("r_streaming", strm.m_valid, 1);
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        chk("r_busy", o_busy, 0);
        chk("r_m_valid", strm.m_valid, 0);
        chk("r_done", o_done, 0);
        chk("r_fft_reset", o_fft_reset, 1);
        chk("r_ce", o_fft_ce, 0);
        tick();
        chk("r_total_order", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
